// File: rtl/data_memory_pkg.sv
// Shared memory parameters for the data memory: default geometry and the
// address-decode helper.
package data_memory_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned DEPTH_DEF   = 256;
  localparam int unsigned IDX_W_DEF   = $clog2(DEPTH_DEF);

  // A word address hits storage only when every bit above the index is zero
  // and the index itself names an implemented word.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       idx_w,
                                         input int unsigned       depth);
    logic upper_zero;
    logic below_depth;
    upper_zero  = ((addr >> idx_w) == '0);
    below_depth = (addr < ADDR_W'(depth));
    return upper_zero && below_depth;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read,
// synchronous clear of every word on reset.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  input  logic              memWriteF,
  input  logic              memReadF,
  output logic [DATA_W-1:0] readData
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  assign idx      = address[IDX_W-1:0];
  assign in_range = addr_in_range(address, IDX_W, DEPTH);

  // Next-state storage: only an in-range write touches a word.
  always_comb begin
    mem_d = mem_q;
    if (memWriteF && in_range) begin
      mem_d[idx] = writeData;
    end
  end

  // Reset wins over a write presented in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read shows the stored word before the edge; no write bypass.
  always_comb begin
    readData = '0;
    if (memReadF && in_range) begin
      readData = mem_q[idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: vector table plus hand-written
// same-cycle read/write and hold sequences, checked through a scoreboard.
module tb_data_memory;

  logic        clock;
  logic        reset;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memWriteF;
  logic        memReadF;
  logic [31:0] readData;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];

  data_memory dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .writeData(writeData),
    .memWriteF(memWriteF),
    .memReadF (memReadF),
    .readData (readData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic wr, input logic rd,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.addr = addr;
    v.wdata = wdata; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic wr, input logic rd,
                       input logic [31:0] addr, input logic [31:0] wdata);
    reset = rst; memWriteF = wr; memReadF = rd;
    address = addr; writeData = wdata;
  endtask

  task automatic expect_rd(input logic [31:0] exp, input string name);
    sb_t e;
    e.exp = exp; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic compare_rd();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: no expected value queued");
      return;
    end
    e = sb_q.pop_front();
    n_checks++;
    if (readData !== e.exp) begin
      n_fail++;
      $display("FAIL %s: readData=0x%08h expected 0x%08h", e.name, readData, e.exp);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    vecs.push_back(mk(1, 0, 0, 32'd0,   32'd0,          32'd0,          "reset_rd_off"));
    vecs.push_back(mk(0, 0, 1, 32'd0,   32'd0,          32'd0,          "after_reset_a0"));
    vecs.push_back(mk(0, 1, 0, 32'd0,   32'd10,         32'd0,          "wr10_a0_rd_off"));
    vecs.push_back(mk(0, 0, 1, 32'd0,   32'd0,          32'd10,         "rd_a0_eq10"));
    vecs.push_back(mk(0, 0, 1, 32'd5,   32'd0,          32'd0,          "rd_a5_eq0"));
    vecs.push_back(mk(0, 1, 0, 32'd5,   32'd1000,       32'd0,          "wr1000_a5"));
    vecs.push_back(mk(0, 0, 1, 32'd5,   32'd0,          32'd1000,       "rd_a5_eq1000"));
    vecs.push_back(mk(0, 0, 1, 32'd0,   32'd0,          32'd10,         "rd_a0_still10"));
    vecs.push_back(mk(0, 0, 0, 32'd5,   32'd0,          32'd0,          "rd_disabled_a5"));
    vecs.push_back(mk(0, 1, 1, 32'd256, 32'd7,          32'd0,          "wr_oor_256"));
    vecs.push_back(mk(0, 0, 1, 32'd0,   32'd0,          32'd10,         "a0_after_oor_wr"));
    vecs.push_back(mk(0, 0, 1, 32'd256, 32'd0,          32'd0,          "rd_oor_256"));
    vecs.push_back(mk(0, 1, 0, 32'h8000_0000, 32'd55,   32'd0,          "wr_oor_msb"));
    vecs.push_back(mk(0, 0, 1, 32'h8000_0000, 32'd0,    32'd0,          "rd_oor_msb"));
    vecs.push_back(mk(0, 0, 1, 32'd0,   32'd0,          32'd10,         "a0_after_msb_wr"));
    vecs.push_back(mk(0, 1, 0, 32'd255, 32'h1234_5678,  32'd0,          "wr_top_word"));
    vecs.push_back(mk(0, 0, 1, 32'd255, 32'd0,          32'h1234_5678,  "rd_top_word"));
    vecs.push_back(mk(0, 0, 1, 32'd254, 32'd0,          32'd0,          "rd_below_top"));
    vecs.push_back(mk(1, 1, 1, 32'd0,   32'hDEAD_BEEF,  32'd10,         "rd_during_reset_a0"));
    vecs.push_back(mk(1, 1, 0, 32'd3,   32'hDEAD_BEEF,  32'd0,          "wr_during_reset_a3"));
    vecs.push_back(mk(0, 0, 1, 32'd3,   32'd0,          32'd0,          "a3_reset_discard"));
    vecs.push_back(mk(0, 0, 1, 32'd0,   32'd0,          32'd0,          "a0_cleared"));
    vecs.push_back(mk(0, 0, 1, 32'd5,   32'd0,          32'd0,          "a5_cleared"));
    vecs.push_back(mk(0, 0, 1, 32'd255, 32'd0,          32'd0,          "a255_cleared"));

    // Each vector: drive at negedge, check the combinational read, then the edge.
    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      expect_rd(vecs[i].exp, vecs[i].name);
      #1;
      compare_rd();
    end

    // Same-cycle read and write of one address: old word, then new word.
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b1, 32'd9, 32'd42);
    expect_rd(32'd0, "rw_a9_before_edge");
    #1;
    compare_rd();
    @(posedge clock);
    #1;
    expect_rd(32'd42, "rw_a9_after_edge");
    compare_rd();

    // Contents hold across idle cycles.
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 32'd9, 32'd99);
    repeat (5) @(negedge clock);
    memReadF = 1'b1;
    expect_rd(32'd42, "a9_holds_idle");
    #1;
    compare_rd();

    // Mid-operation reset clears prior writes at the next edge.
    @(negedge clock);
    drive(1'b1, 1'b0, 1'b1, 32'd9, 32'd0);
    expect_rd(32'd42, "a9_before_mid_reset");
    #1;
    compare_rd();
    @(posedge clock);
    #1;
    expect_rd(32'd0, "a9_after_mid_reset");
    compare_rd();

    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
